// File: rtl/brnch_pred_resolve_ctrl.sv
// brnch_pred_resolve_ctrl: in-flight branch prediction queue, resolve compare, predictor update
// pulse, mispredict flush/redirect sequencing and saturating performance counters.
module brnch_pred_resolve_ctrl #(
    parameter int DEPTH     = 4,
    parameter int FLUSH_CYC = 2,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             brch_instr_detectd_IF,
    input  logic             predict_br_taken,
    input  logic             if_stall,
    input  logic             brch_resolve_vld,
    input  logic             brch_hazard_stall,
    input  logic             actual_brch_result,
    output logic             upd_pred_state,
    output logic             upd_br_result,
    output logic             mispredict_flush,
    output logic             redirect_taken,
    output logic             ctrl_stall_IF,
    output logic [CNT_W-1:0] num_branches,
    output logic [CNT_W-1:0] num_mispred,
    output logic             resolve_err
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int FW = $clog2(FLUSH_CYC + 1);
    localparam logic [CW-1:0] FULL  = CW'(DEPTH);
    localparam logic [FW-1:0] FLAST = FW'(FLUSH_CYC - 1);

    typedef enum logic {RUN, FLUSH} state_t;

    state_t           state_q, state_d;
    logic [FW-1:0]    fcnt_q, fcnt_d;
    logic [DEPTH-1:0] mem_q, mem_d;
    logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0] nbr_q, nbr_d, nmp_q, nmp_d;
    logic             upd_q, res_q, redir_q, stall_q, err_q;
    logic             run, push_req, push, acc, pop, mispred, overflow;

    assign run      = state_q == RUN;
    assign push_req = brch_instr_detectd_IF & ~if_stall & run;
    assign push     = push_req & ~stall_q;
    assign acc      = brch_resolve_vld & ~brch_hazard_stall & run;
    assign pop      = acc & (cnt_q != '0);
    assign mispred  = pop & (mem_q[rd_q] != actual_brch_result);
    // Full queue is already stalled, so a push here means IF ignored the stall.
    assign overflow = push_req & (cnt_q == FULL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
        end
    end

    always_comb begin
        state_d = run ? (mispred ? FLUSH : RUN) : (fcnt_q == FLAST ? RUN : FLUSH);
        fcnt_d  = run ? '0 : fcnt_q + 1'b1;
    end

    always_comb begin
        mispredict_flush = state_q == FLUSH;
        redirect_taken   = mispredict_flush & redir_q;
        upd_pred_state   = upd_q;
        upd_br_result    = res_q;
        ctrl_stall_IF    = stall_q;
        num_branches     = nbr_q;
        num_mispred      = nmp_q;
        resolve_err      = err_q;
    end

    // A mispredict empties the queue; everything younger is wrong-path, including a same-cycle push.
    always_comb begin
        mem_d = mem_q;
        if (push && !mispred) mem_d[wr_q] = predict_br_taken;
        wr_d  = mispred ? '0 : wr_q + PW'(push);
        rd_d  = mispred ? '0 : rd_q + PW'(pop);
        cnt_d = mispred ? '0 : cnt_q + CW'(push) - CW'(pop);
        nbr_d = (pop && !(&nbr_q)) ? nbr_q + 1'b1 : nbr_q;
        nmp_d = (mispred && !(&nmp_q)) ? nmp_q + 1'b1 : nmp_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            nbr_q   <= '0;
            nmp_q   <= '0;
            upd_q   <= 1'b0;
            res_q   <= 1'b0;
            redir_q <= 1'b0;
            stall_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            mem_q   <= mem_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            nbr_q   <= nbr_d;
            nmp_q   <= nmp_d;
            upd_q   <= pop;
            res_q   <= pop & actual_brch_result;
            redir_q <= mispred ? actual_brch_result : redir_q;
            stall_q <= (cnt_d == FULL) | (state_d == FLUSH);
            err_q   <= err_q | (acc & (cnt_q == '0)) | overflow;
        end
    end
endmodule

// File: tb/tb_brnch_pred_resolve_ctrl.sv
// tb_brnch_pred_resolve_ctrl: directed scenarios plus random traffic, checked every cycle
// against a queue-based model of the prediction/resolve rules.
module tb_brnch_pred_resolve_ctrl;
    localparam int DEPTH     = 4;
    localparam int FLUSH_CYC = 2;
    localparam int CNT_W     = 16;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic brch_instr_detectd_IF = 1'b0, predict_br_taken = 1'b0, if_stall = 1'b0;
    logic brch_resolve_vld = 1'b0, brch_hazard_stall = 1'b0, actual_brch_result = 1'b0;
    logic upd_pred_state, upd_br_result, mispredict_flush, redirect_taken, ctrl_stall_IF, resolve_err;
    logic [CNT_W-1:0] num_branches, num_mispred;

    int vectors = 0;
    int miscompares = 0;

    bit pq[$];
    int flush_left;
    bit redir_m;
    bit exp_upd, exp_res, exp_flush, exp_redir, exp_stall, exp_err;
    int exp_nb, exp_nm;

    brnch_pred_resolve_ctrl #(.DEPTH(DEPTH), .FLUSH_CYC(FLUSH_CYC), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .brch_instr_detectd_IF(brch_instr_detectd_IF), .predict_br_taken(predict_br_taken),
        .if_stall(if_stall), .brch_resolve_vld(brch_resolve_vld),
        .brch_hazard_stall(brch_hazard_stall), .actual_brch_result(actual_brch_result),
        .upd_pred_state(upd_pred_state), .upd_br_result(upd_br_result),
        .mispredict_flush(mispredict_flush), .redirect_taken(redirect_taken),
        .ctrl_stall_IF(ctrl_stall_IF), .num_branches(num_branches),
        .num_mispred(num_mispred), .resolve_err(resolve_err)
    );

    always #5 clk = ~clk;

    task automatic cmp(string name, logic [31:0] got, logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, want);
        end
    endtask

    task automatic check_all();
        cmp("upd_pred_state", 32'(upd_pred_state), 32'(exp_upd));
        cmp("upd_br_result", 32'(upd_br_result), 32'(exp_res));
        cmp("mispredict_flush", 32'(mispredict_flush), 32'(exp_flush));
        cmp("redirect_taken", 32'(redirect_taken), 32'(exp_redir));
        cmp("ctrl_stall_IF", 32'(ctrl_stall_IF), 32'(exp_stall));
        cmp("num_branches", 32'(num_branches), 32'(exp_nb));
        cmp("num_mispred", 32'(num_mispred), 32'(exp_nm));
        cmp("resolve_err", 32'(resolve_err), 32'(exp_err));
    endtask

    task automatic model_reset();
        pq.delete();
        flush_left = 0;
        redir_m = 0;
        {exp_upd, exp_res, exp_flush, exp_redir, exp_stall, exp_err} = '0;
        exp_nb = 0;
        exp_nm = 0;
    endtask

    task automatic model_step(bit det, bit pt, bit ifs, bit rv, bit hz, bit act);
        bit run, want_push, accept, popping, mis, head;
        run       = flush_left == 0;
        want_push = det && !ifs && run;
        accept    = rv && !hz && run;
        popping   = accept && pq.size() > 0;
        if (want_push && pq.size() == DEPTH) exp_err = 1;
        if (accept && pq.size() == 0) exp_err = 1;
        if (!run) flush_left--;
        mis = 0;
        if (popping) begin
            head = pq.pop_front();
            mis = head != act;
            exp_nb = (exp_nb < CNT_MAX) ? exp_nb + 1 : exp_nb;
        end
        if (mis) begin
            pq.delete();
            exp_nm = (exp_nm < CNT_MAX) ? exp_nm + 1 : exp_nm;
            flush_left = FLUSH_CYC;
            redir_m = act;
        end else if (want_push && !exp_stall) begin
            pq.push_back(pt);
        end
        exp_upd   = popping;
        exp_res   = popping && act;
        exp_flush = flush_left > 0;
        exp_redir = exp_flush && redir_m;
        exp_stall = pq.size() == DEPTH || flush_left > 0;
    endtask

    task automatic cyc(bit det, bit pt, bit ifs, bit rv, bit hz, bit act);
        brch_instr_detectd_IF = det;
        predict_br_taken      = pt;
        if_stall              = ifs;
        brch_resolve_vld      = rv;
        brch_hazard_stall     = hz;
        actual_brch_result    = act;
        model_step(det, pt, ifs, rv, hz, act);
        @(posedge clk);
        #2;
        check_all();
    endtask

    task automatic do_reset();
        #1;
        rst_n = 1'b0;
        {brch_instr_detectd_IF, predict_br_taken, if_stall} = '0;
        {brch_resolve_vld, brch_hazard_stall, actual_brch_result} = '0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic push(bit pt);
        cyc(1, pt, 0, 0, 0, 0);
    endtask

    task automatic resolve(bit act);
        cyc(0, 0, 0, 1, 0, act);
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        model_reset();
        do_reset();

        // basic: T,N,T predicted and resolved the same way
        push(1); push(0); push(1);
        resolve(1);
        cmp("basic_upd1", 32'(upd_br_result), 32'd1);
        resolve(0);
        cmp("basic_upd2", 32'(upd_pred_state), 32'd1);
        resolve(1);
        idle();
        cmp("basic_nb", 32'(num_branches), 32'd3);
        cmp("basic_nm", 32'(num_mispred), 32'd0);
        cmp("basic_flush", 32'(mispredict_flush), 32'd0);

        // mispredict on the first of T,T,N
        do_reset();
        push(1); push(1); push(0);
        resolve(0);
        cmp("mis_flush1", 32'(mispredict_flush), 32'd1);
        cmp("mis_redir", 32'(redirect_taken), 32'd0);
        cmp("mis_stall", 32'(ctrl_stall_IF), 32'd1);
        resolve(1);
        cmp("mis_flush2", 32'(mispredict_flush), 32'd1);
        cmp("mis_err_in_flush", 32'(resolve_err), 32'd0);
        resolve(1);
        cmp("mis_flush_end", 32'(mispredict_flush), 32'd0);
        cmp("mis_no_upd", 32'(upd_pred_state), 32'd0);
        cmp("mis_nm", 32'(num_mispred), 32'd1);

        // taken mispredict: redirect high, push on the same cycle discarded
        do_reset();
        push(0);
        cyc(1, 1, 0, 1, 0, 1);
        cmp("mis_redir_t", 32'(redirect_taken), 32'd1);
        idle(); idle();
        resolve(1);
        cmp("mis_push_dropped_err", 32'(resolve_err), 32'd1);

        // full queue
        do_reset();
        push(1); push(0); push(1);
        cmp("full_not_yet", 32'(ctrl_stall_IF), 32'd0);
        push(0);
        cmp("full_stall", 32'(ctrl_stall_IF), 32'd1);
        push(1);
        cmp("full_stall_hold", 32'(ctrl_stall_IF), 32'd1);
        resolve(1);
        cmp("full_stall_drop", 32'(ctrl_stall_IF), 32'd0);
        resolve(0); resolve(1); resolve(0);
        cmp("full_nb", 32'(num_branches), 32'd4);

        // hazard stall holds the resolve
        do_reset();
        push(1);
        repeat (3) begin
            cyc(0, 0, 0, 1, 1, 1);
            cmp("haz_no_upd", 32'(upd_pred_state), 32'd0);
        end
        resolve(1);
        cmp("haz_upd", 32'(upd_pred_state), 32'd1);
        idle();
        cmp("haz_single", 32'(upd_pred_state), 32'd0);

        // empty resolve is sticky until reset
        do_reset();
        resolve(1);
        cmp("empty_err", 32'(resolve_err), 32'd1);
        cmp("empty_no_upd", 32'(upd_pred_state), 32'd0);
        idle(); idle();
        cmp("empty_err_sticky", 32'(resolve_err), 32'd1);

        // reset with entries queued, then reset mid-flush
        do_reset();
        push(1); push(0);
        do_reset();
        push(1); push(1); push(0);
        resolve(0);
        do_reset();
        cmp("rst_flush", 32'(mispredict_flush), 32'd0);
        cmp("rst_stall", 32'(ctrl_stall_IF), 32'd0);
        push(1);
        resolve(1);
        cmp("rst_after_upd", 32'(upd_br_result), 32'd1);
        cmp("rst_after_nb", 32'(num_branches), 32'd1);

        // random traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 4,
                $urandom_range(0, 4) == 0, 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
